// File: rtl/hamming_encode_engine_if.sv
// Byte-wide single-port data memory bus between the Hamming encode engine
// (master) and the data memory (slave).
//   mem_addr  : byte address, driven by the master
//   mem_rd_en : read strobe; mem_rdata is valid one cycle later
//   mem_rdata : read data, driven by the memory
//   mem_wr_en : write strobe; mem_wdata is written at the clock edge
//   mem_wdata : write data, driven by the master
interface hamming_encode_engine_if #(
    parameter int AW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        output mem_wr_en,
        output mem_wdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        input  mem_wr_en,
        input  mem_wdata
    );
endinterface

// File: rtl/hamming_encode_engine.sv
// SECDED Hamming(16,11) encoder engine. On start it walks NUM_WORDS raw
// 11-bit messages (two bytes each at SRC_BASE), computes the parity bits
// and writes the 16-bit encoded words (low byte first) at DST_BASE.
// Five cycles per message: RD_LO, RD_HI, CAP, WR_LO, WR_HI.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : synchronous, active-high reset
//   i_start : single-cycle request to begin a pass (IDLE/DONE only)
//   mem     : memory bus master (address, read/write strobes, data)
//   o_busy  : high while a pass is in progress
//   o_halt  : done flag, sticky until the next accepted start or reset
module hamming_encode_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30,
    parameter int AW        = 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_start,
    hamming_encode_engine_if.master        mem,
    output logic                           o_busy,
    output logic                           o_halt
);
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [AW-1:0] SRC_A  = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A  = AW'(DST_BASE);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_CAP   = 3'd3,
        S_WR_LO = 3'd4,
        S_WR_HI = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    // Encoded word layout {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.
    function automatic logic [15:0] f_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

    state_t        r_state, w_state_nx;
    logic [IW-1:0] r_idx, w_idx_nx, w_idx_inc;
    logic [AW-1:0] r_addr, w_addr_nx;
    logic          r_rd_en, w_rd_en_nx;
    logic          r_wr_en, w_wr_en_nx;
    logic [7:0]    r_wdata, w_wdata_nx;
    logic          r_busy, w_busy_nx;
    logic          r_halt, w_halt_nx;
    logic [7:0]    r_lo, w_lo_nx;
    logic [2:0]    r_hi, w_hi_nx;
    logic [AW-1:0] w_off, w_off_inc;
    logic [15:0]   w_enc_cap, w_enc_reg;
    logic          w_unused_rdata;

    // Upper bits of the message high byte carry no data.
    assign w_unused_rdata = ^mem.mem_rdata[7:3];

    assign w_idx_inc = r_idx + {{(IW-1){1'b0}}, 1'b1};
    assign w_off     = AW'({r_idx, 1'b0});
    assign w_off_inc = AW'({w_idx_inc, 1'b0});
    // In CAP the high byte is still on the read bus, so the low encoded byte
    // for WR_LO is built from it directly; WR_HI uses the captured copy.
    assign w_enc_cap = f_encode({mem.mem_rdata[2:0], r_lo});
    assign w_enc_reg = f_encode({r_hi, r_lo});

    // State, index, captured message and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_addr  <= '0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_wdata <= 8'h00;
            r_busy  <= 1'b0;
            r_halt  <= 1'b0;
            r_lo    <= 8'h00;
            r_hi    <= 3'b000;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_addr  <= w_addr_nx;
            r_rd_en <= w_rd_en_nx;
            r_wr_en <= w_wr_en_nx;
            r_wdata <= w_wdata_nx;
            r_busy  <= w_busy_nx;
            r_halt  <= w_halt_nx;
            r_lo    <= w_lo_nx;
            r_hi    <= w_hi_nx;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_addr_nx  = r_addr;
        w_rd_en_nx = 1'b0;
        w_wr_en_nx = 1'b0;
        w_wdata_nx = r_wdata;
        w_lo_nx    = r_lo;
        w_hi_nx    = r_hi;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_nx = S_RD_LO;
                    w_idx_nx   = '0;
                    w_addr_nx  = SRC_A;
                    w_rd_en_nx = 1'b1;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_RD_LO: begin
                w_state_nx = S_RD_HI;
                w_addr_nx  = SRC_A + w_off + {{(AW-1){1'b0}}, 1'b1};
                w_rd_en_nx = 1'b1;
            end
            S_RD_HI: begin
                w_state_nx = S_CAP;
                w_lo_nx    = mem.mem_rdata;
            end
            S_CAP: begin
                w_state_nx = S_WR_LO;
                w_hi_nx    = mem.mem_rdata[2:0];
                w_addr_nx  = DST_A + w_off;
                w_wr_en_nx = 1'b1;
                w_wdata_nx = w_enc_cap[7:0];
            end
            S_WR_LO: begin
                w_state_nx = S_WR_HI;
                w_addr_nx  = DST_A + w_off + {{(AW-1){1'b0}}, 1'b1};
                w_wr_en_nx = 1'b1;
                w_wdata_nx = w_enc_reg[15:8];
            end
            S_WR_HI: begin
                if (r_idx == LAST_I) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_RD_LO;
                    w_idx_nx   = w_idx_inc;
                    w_addr_nx  = SRC_A + w_off_inc;
                    w_rd_en_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_idx_nx   = '0;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);
        w_halt_nx = (w_state_nx == S_DONE);
    end

    assign mem.mem_addr  = r_addr;
    assign mem.mem_rd_en = r_rd_en;
    assign mem.mem_wr_en = r_wr_en;
    assign mem.mem_wdata = r_wdata;
    assign o_busy        = r_busy;
    assign o_halt        = r_halt;
endmodule

// File: tb/tb_hamming_encode_engine.sv
module tb_hamming_encode_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, halt;

    hamming_encode_engine_if #(.AW(8)) mem_if ();

    hamming_encode_engine #(
        .NUM_WORDS(15), .SRC_BASE(0), .DST_BASE(30), .AW(8)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .mem(mem_if.master), .o_busy(busy), .o_halt(halt)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_a = 8'h00;
    logic [7:0] tb_d = 8'h00;
    int         bad_wr = 0;
    int         overlap = 0;

    // Memory model: synchronous read, write at the edge; bench backdoor load wins.
    always @(posedge clk) begin
        if (tb_we) mem[tb_a] <= tb_d;
        else if (mem_if.mem_wr_en) mem[mem_if.mem_addr] <= mem_if.mem_wdata;
        if (mem_if.mem_rd_en) mem_if.mem_rdata <= mem[mem_if.mem_addr];
    end

    // Bus monitor: writes outside the destination image and strobe overlap.
    always @(posedge clk) begin
        if (!reset && mem_if.mem_wr_en && (mem_if.mem_addr < 8'd30 || mem_if.mem_addr > 8'd59))
            bad_wr <= bad_wr + 1;
        if (mem_if.mem_wr_en && mem_if.mem_rd_en) overlap <= overlap + 1;
    end

    int n_checks = 0;
    int n_errs = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: place data in Hamming positions 3,5,6,7,9..15; parity at
    // power-of-two positions; bit 0 is overall parity.
    function automatic logic [15:0] ref_enc(input logic [10:0] m);
        logic [15:0] c;
        int k;
        logic par;
        c = 16'h0000;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = m[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos >> b) & 1) == 1) par = par ^ c[pos];
            c[1 << b] = par;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    logic [7:0]  src_lo [15];
    logic [7:0]  src_hi [15];
    logic [15:0] saved [15];

    function automatic logic [15:0] dst_word(input int i);
        return {mem[31 + 2*i], mem[30 + 2*i]};
    endfunction

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load_all(input logic [7:0] fill);
        for (int i = 0; i < 15; i++) begin
            load_byte(8'(2*i), src_lo[i]);
            load_byte(8'(2*i + 1), src_hi[i]);
        end
        for (int a = 30; a < 60; a++) load_byte(8'(a), fill);
    endtask

    function automatic int dst_errs(input int nwords);
        int e = 0;
        for (int i = 0; i < nwords; i++)
            if (dst_word(i) !== ref_enc({src_hi[i][2:0], src_lo[i]})) e++;
        return e;
    endfunction

    function automatic int src_errs();
        int e = 0;
        for (int i = 0; i < 15; i++)
            if (mem[2*i] !== src_lo[i] || mem[2*i + 1] !== src_hi[i]) e++;
        return e;
    endfunction

    // Start a pass and follow it cycle by cycle (cycle n = n edges after start edge).
    task automatic run_pass(input int glitch, input int abort, output int halt_cyc, output int busy_bad);
        logic exp_busy;
        halt_cyc = -1;
        busy_bad = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            exp_busy = (n <= 75);
            if (busy !== exp_busy) busy_bad++;
            if (halt === 1'b1) begin
                halt_cyc = n;
                break;
            end
            start = (n == glitch);
            if (n == abort) begin
                reset = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    int hc, bb;

    initial begin
        repeat (3) @(negedge clk);
        chk_val("rst_addr", 32'(mem_if.mem_addr), 32'h0);
        chk_val("rst_rd", 32'(mem_if.mem_rd_en), 32'h0);
        chk_val("rst_wr", 32'(mem_if.mem_wr_en), 32'h0);
        chk_val("rst_wdata", 32'(mem_if.mem_wdata), 32'h0);
        chk_val("rst_busy", 32'(busy), 32'h0);
        chk_val("rst_halt", 32'(halt), 32'h0);
        reset = 1'b0;

        // All-zero messages.
        for (int i = 0; i < 15; i++) begin src_lo[i] = 8'h00; src_hi[i] = 8'h00; end
        load_all(8'h5A);
        run_pass(0, 0, hc, bb);
        chk_val("zero_halt_cyc", 32'(hc), 32'd76);
        chk_val("zero_busy", 32'(bb), 32'd0);
        chk_val("zero_w0", 32'(dst_word(0)), 32'h0000);
        chk_val("zero_w14", 32'(dst_word(14)), 32'h0000);
        chk_val("zero_model", 32'(dst_errs(15)), 32'd0);

        // All-ones messages.
        for (int i = 0; i < 15; i++) begin src_lo[i] = 8'hFF; src_hi[i] = 8'h07; end
        load_all(8'h00);
        run_pass(0, 0, hc, bb);
        chk_val("ones_halt_cyc", 32'(hc), 32'd76);
        chk_val("ones_w0", 32'(dst_word(0)), 32'hFFFF);
        chk_val("ones_w14", 32'(dst_word(14)), 32'hFFFF);

        // Directed single-bit / ignored-bit messages plus random fill.
        for (int i = 0; i < 15; i++) begin
            src_lo[i] = 8'($urandom_range(255));
            src_hi[i] = 8'($urandom_range(255));
        end
        src_lo[0] = 8'h01; src_hi[0] = 8'h00;
        src_lo[1] = 8'h00; src_hi[1] = 8'h04;
        src_lo[2] = 8'h00; src_hi[2] = 8'hFC;
        load_all(8'hC3);
        run_pass(0, 0, hc, bb);
        chk_val("dir_halt_cyc", 32'(hc), 32'd76);
        chk_val("dir_busy", 32'(bb), 32'd0);
        chk_val("dir_w0_0x001", 32'(dst_word(0)), 32'h000F);
        chk_val("dir_w1_0x400", 32'(dst_word(1)), 32'h8117);
        chk_val("dir_w2_hiFC", 32'(dst_word(2)), 32'h8117);
        chk_val("dir_model", 32'(dst_errs(15)), 32'd0);
        chk_val("dir_src_kept", 32'(src_errs()), 32'd0);
        for (int i = 0; i < 15; i++) saved[i] = dst_word(i);

        // Same pass with a stray start at cycle 20.
        load_all(8'h3C);
        run_pass(20, 0, hc, bb);
        chk_val("glitch_halt_cyc", 32'(hc), 32'd76);
        chk_val("glitch_busy", 32'(bb), 32'd0);
        begin
            int e = 0;
            for (int i = 0; i < 15; i++) if (dst_word(i) !== saved[i]) e++;
            chk_val("glitch_same", 32'(e), 32'd0);
        end

        // Reset at cycle 40: messages 0..7 complete, the rest untouched.
        load_all(8'hA5);
        run_pass(0, 40, hc, bb);
        @(negedge clk);
        chk_val("abort_outs", {mem_if.mem_addr, 6'd0, mem_if.mem_rd_en, mem_if.mem_wr_en,
                               mem_if.mem_wdata, 6'd0, busy, halt}, 32'h0);
        reset = 1'b0;
        begin
            int act = 0;
            for (int n = 0; n < 4; n++) begin
                @(negedge clk);
                if (mem_if.mem_rd_en || mem_if.mem_wr_en || busy) act++;
            end
            chk_val("abort_idle", 32'(act), 32'd0);
        end
        chk_val("abort_done_words", 32'(dst_errs(8)), 32'd0);
        begin
            int e = 0;
            for (int a = 46; a < 60; a++) if (mem[a] !== 8'hA5) e++;
            chk_val("abort_untouched", 32'(e), 32'd0);
        end
        run_pass(0, 0, hc, bb);
        chk_val("rerun_halt_cyc", 32'(hc), 32'd76);
        chk_val("rerun_model", 32'(dst_errs(15)), 32'd0);
        chk_val("rerun_src_kept", 32'(src_errs()), 32'd0);

        @(negedge clk);
        chk_val("halt_sticky", 32'(halt), 32'd1);
        chk_val("no_stray_write", 32'(bad_wr), 32'd0);
        chk_val("no_rd_wr_overlap", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
